generic_rom_arbiter: RTL and testbench

Round-robin arbiter that shares one registered-output, single-port ROM instance (generic_rom) among N_PORTS requesters. Each requester issues addresses over a valid/ready handshake. The arbiter accepts at most one request per clock and drives the winning address to the ROM. It tracks in-flight reads with a tag pipeline matched to the ROM read latency and returns the read data to the originating port. The block sits between CPU/DMA-style read clients and a shared generic_rom, giving full one-read-per-cycle throughput.

---
 rtl/generic_rom_arbiter.sv | 55 +++++
 tb/tb_generic_rom_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/generic_rom_arbiter.sv
// generic_rom_arbiter: round-robin sharing of one pipelined ROM among N requesters
module generic_rom_arbiter #(
  parameter int N_PORTS       = 2,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 10,
  parameter int ROM_LATENCY   = 2
) (
  input  logic                               i_clk,
  input  logic                               i_rstn,
  input  logic [N_PORTS-1:0]                 i_req_valid,
  input  logic [N_PORTS*ADDRESS_WIDTH-1:0]   i_req_addr,
  output logic [N_PORTS-1:0]                 o_req_ready,
  output logic [N_PORTS-1:0]                 o_rsp_valid,
  output logic [DATA_WIDTH-1:0]              o_rsp_data,
  output logic [ADDRESS_WIDTH-1:0]           o_rom_address,
  input  logic [DATA_WIDTH-1:0]              i_rom_read_data,
  output logic                               o_busy
);
  localparam int PW = N_PORTS > 1 ? $clog2(N_PORTS) : 1;
  logic [PW-1:0] ptr, win;
  logic found;
  logic [2*N_PORTS-1:0] rot;
  logic [ROM_LATENCY-1:0] tag_valid;
  logic [PW-1:0] tag_port [ROM_LATENCY];
  // rotating the doubled request vector puts ptr at bit 0, so the first set bit is the winner offset
  assign rot = {i_req_valid, i_req_valid} >> ptr;
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int i = 0; i < N_PORTS; i++)
      if (!found && rot[i]) begin
        found = 1'b1;
        win = PW'(int'(ptr) + i >= N_PORTS ? int'(ptr) + i - N_PORTS : int'(ptr) + i);
      end
  end
  assign o_req_ready   = found ? {{(N_PORTS-1){1'b0}}, 1'b1} << win : '0;
  assign o_rom_address = found ? i_req_addr[win*ADDRESS_WIDTH +: ADDRESS_WIDTH] : '0;
  assign o_rsp_valid   = tag_valid[ROM_LATENCY-1] ? {{(N_PORTS-1){1'b0}}, 1'b1} << tag_port[ROM_LATENCY-1] : '0;
  assign o_rsp_data    = i_rom_read_data;
  assign o_busy        = |i_req_valid | |tag_valid;
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      ptr <= '0;
      tag_valid <= '0;
      for (int k = 0; k < ROM_LATENCY; k++) tag_port[k] <= '0;
    end else begin
      if (found) ptr <= win == PW'(N_PORTS-1) ? '0 : win + 1'b1;
      tag_valid[0] <= found;
      tag_port[0] <= win;
      for (int k = 1; k < ROM_LATENCY; k++) begin
        tag_valid[k] <= tag_valid[k-1];
        tag_port[k] <= tag_port[k-1];
      end
    end
endmodule

// File: tb/tb_generic_rom_arbiter.sv
// tb_generic_rom_arbiter: randomized and directed checks against a queue-based reference model
module tb_generic_rom_arbiter;
  localparam int N = 3, DW = 32, AW = 10, L = 2;
  logic clk = 1'b0, rstn = 1'b0;
  logic [N-1:0] req_valid = '0, ready, rsp_valid;
  logic [N*AW-1:0] req_addr = '0;
  logic [DW-1:0] rsp_data, rom_data;
  logic [AW-1:0] rom_address, rom_q;
  logic busy;
  typedef struct {int due; int port; logic [DW-1:0] data;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0, cyc = 0, model_ptr = 0;
  bit rst_pending = 0, last_rsp = 0;
  int grants[$], rsp_ports[$], rsp_cycs[$];
  logic [DW-1:0] rsp_datas[$];

  generic_rom_arbiter #(.N_PORTS(N), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ROM_LATENCY(L)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_req_valid(req_valid), .i_req_addr(req_addr),
    .o_req_ready(ready), .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
    .o_rom_address(rom_address), .i_rom_read_data(rom_data), .o_busy(busy));

  // two-edge registered ROM, word[a] = A000_0000 | a
  always @(posedge clk) begin
    rom_q <= rom_address;
    rom_data <= 32'hA000_0000 | 32'(rom_q);
  end
  always #5 clk = ~clk;

  function automatic logic [N*AW-1:0] pack(input int a0, input int a1, input int a2);
    return {AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  task automatic clear_logs();
    grants.delete(); rsp_ports.delete(); rsp_cycs.delete(); rsp_datas.delete();
  endtask

  task automatic cycle(input logic [N-1:0] v, input logic [N*AW-1:0] a);
    int w;
    logic [N-1:0] er, ev;
    logic [AW-1:0] ea;
    logic eb;
    req_valid = v; req_addr = a;
    #1;
    w = -1;
    for (int i = 0; i < N; i++) if (w < 0 && v[(model_ptr + i) % N]) w = (model_ptr + i) % N;
    er = '0; ea = '0;
    if (w >= 0) begin er[w] = 1'b1; ea = a[w*AW +: AW]; end
    tests++;
    if (ready !== er || rom_address !== ea) begin
      fails++;
      $display("FAIL grant cyc=%0d ready=%b addr=%h expected ready=%b addr=%h", cyc, ready, rom_address, er, ea);
    end
    eb = (|v) || q.size() > 0 || last_rsp;
    tests++;
    if (busy !== eb) begin fails++; $display("FAIL busy cyc=%0d got=%b expected=%b", cyc, busy, eb); end
    @(posedge clk);
    cyc++;
    if (w >= 0) begin
      q.push_back(exp_t'{cyc + L - 1, w, 32'hA000_0000 | 32'(ea)});
      model_ptr = (w + 1) % N;
      grants.push_back(w);
    end
    if (rst_pending) begin rstn = 1'b0; q.delete(); model_ptr = 0; rst_pending = 0; end
    #1;
    ev = '0; last_rsp = 0;
    if (q.size() > 0 && q[0].due == cyc) ev[q[0].port] = 1'b1;
    tests++;
    if (rsp_valid !== ev || (ev != 0 && rsp_data !== q[0].data)) begin
      fails++;
      $display("FAIL response cyc=%0d valid=%b data=%h expected valid=%b data=%h", cyc, rsp_valid, rsp_data, ev,
               ev != 0 ? q[0].data : 32'h0);
    end
    for (int p = 0; p < N; p++) if (rsp_valid[p]) begin rsp_ports.push_back(p); rsp_cycs.push_back(cyc); rsp_datas.push_back(rsp_data); end
    if (ev != 0) begin void'(q.pop_front()); last_rsp = 1; end
  endtask

  task automatic do_reset();
    req_valid = '0; rstn = 1'b0;
    q.delete(); model_ptr = 0; last_rsp = 0;
    @(posedge clk); #1;
    rstn = 1'b1;
    clear_logs();
  endtask

  task automatic test_reset();
    rstn = 1'b0; req_valid = '0; req_addr = '0;
    #12;
    tests++;
    if (rsp_valid !== '0 || busy !== 1'b0 || ready !== '0 || rom_address !== '0) begin
      fails++; $display("FAIL reset_idle valid=%b busy=%b ready=%b addr=%h expected all zero", rsp_valid, busy, ready, rom_address);
    end
    req_valid = 3'b110; req_addr = pack(1, 2, 3);
    #1;
    tests++;
    if (ready !== 3'b010 || rom_address !== 10'd2 || busy !== 1'b1) begin
      fails++; $display("FAIL reset_comb ready=%b addr=%h busy=%b expected 010/002/1", ready, rom_address, busy);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    cycle(3'b010, pack(0, 5, 0));
    for (int i = 0; i < 3; i++) cycle(3'b000, '0);
    tests++;
    if (grants.size() != 1 || rsp_ports.size() != 1 || rsp_ports[0] != 1 || rsp_datas[0] !== 32'hA000_0005 || rsp_cycs[0] != 2) begin
      fails++; $display("FAIL single n_rsp=%0d expected port 1 data A0000005 at cycle 2", rsp_ports.size());
    end
  endtask

  task automatic test_contention();
    int eg[6] = '{0, 1, 2, 0, 1, 2};
    logic [DW-1:0] ed[3] = '{32'hA000_0010, 32'hA000_0020, 32'hA000_0030};
    bit ok;
    do_reset();
    for (int i = 0; i < 6; i++) cycle(3'b111, pack(16, 32, 48));
    for (int i = 0; i < 3; i++) cycle(3'b000, '0);
    ok = grants.size() == 6 && rsp_ports.size() == 6;
    for (int i = 0; ok && i < 6; i++)
      ok = grants[i] == eg[i] && rsp_ports[i] == eg[i] && rsp_datas[i] === ed[i % 3] && rsp_cycs[i] == rsp_cycs[0] + i;
    tests++;
    if (!ok) begin fails++; $display("FAIL contention grants=%0d rsps=%0d expected 6 round-robin consecutive", grants.size(), rsp_ports.size()); end
  endtask

  task automatic test_streaming();
    bit ok;
    do_reset();
    for (int i = 0; i < 8; i++) cycle(3'b100, pack(0, 0, i));
    for (int i = 0; i < 3; i++) cycle(3'b000, '0);
    ok = rsp_ports.size() == 8;
    for (int i = 0; ok && i < 8; i++)
      ok = grants[i] == 2 && rsp_ports[i] == 2 && rsp_datas[i] === (32'hA000_0000 | 32'(i)) && rsp_cycs[i] == rsp_cycs[0] + i;
    tests++;
    if (!ok) begin fails++; $display("FAIL streaming rsps=%0d expected 8 consecutive on port 2", rsp_ports.size()); end
  endtask

  task automatic test_fairness();
    do_reset();
    cycle(3'b001, pack(1, 0, 0));
    cycle(3'b101, pack(2, 0, 3));
    cycle(3'b101, pack(2, 0, 3));
    for (int i = 0; i < 3; i++) cycle(3'b000, '0);
    tests++;
    if (grants.size() != 3 || grants[0] != 0 || grants[1] != 2 || grants[2] != 0) begin
      fails++; $display("FAIL fairness grants=%0d expected order 0,2,0", grants.size());
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    cycle(3'b001, pack(3, 0, 0));
    rst_pending = 1;
    cycle(3'b010, pack(0, 4, 0));
    cycle(3'b000, '0);
    rstn = 1'b1;
    cycle(3'b100, pack(0, 0, 7));
    cycle(3'b110, pack(0, 9, 8));
    for (int i = 0; i < 3; i++) cycle(3'b000, '0);
    tests++;
    if (rsp_ports.size() != 2 || rsp_ports[0] != 2 || rsp_datas[0] !== 32'hA000_0007 || rsp_ports[1] != 1 || rsp_datas[1] !== 32'hA000_0009) begin
      fails++; $display("FAIL reset_midflight rsps=%0d expected only port 2 then port 1", rsp_ports.size());
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 4; i++) cycle(3'b000, pack($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023)));
    tests++;
    if (ready !== '0 || rom_address !== '0 || rsp_valid !== '0 || busy !== 1'b0) begin
      fails++; $display("FAIL idle ready=%b addr=%h valid=%b busy=%b expected all zero", ready, rom_address, rsp_valid, busy);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++)
      cycle(N'($urandom_range(0, 7)), pack($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023)));
    for (int i = 0; i < 3; i++) cycle(3'b000, '0);
    tests++;
    if (rsp_ports.size() != grants.size()) begin
      fails++; $display("FAIL random_count rsps=%0d expected %0d", rsp_ports.size(), grants.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_streaming();
    test_fairness();
    test_reset_midflight();
    test_idle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
